// File: rtl/femto_pkg.sv
// -----------------------------------------------------------------------------
// femto_pkg
//   Shared encodings for the femto sequencer and its instruction store.
//   - Mode (FSM state) and command encodings.
//   - Instruction field widths/offsets: op[2:0], reg_0[4:3], reg_1[6:5].
//   - cmd_to_mode(): maps an accepted command onto the state it selects.
// -----------------------------------------------------------------------------
package femto_pkg;

    // Instruction layout
    localparam int OP_W     = 3;
    localparam int RF_W     = 2;
    localparam int INSTR_W  = OP_W + 2 * RF_W;
    localparam int OP_LSB   = 0;
    localparam int RF0_LSB  = OP_LSB + OP_W;
    localparam int RF1_LSB  = RF0_LSB + RF_W;

    // Op 0 neither reads nor writes the register file, so a zero word is a
    // safe filler whenever nothing is issued.
    localparam logic [OP_W-1:0] OP_NOP = '0;

    // FSM state encoding (also driven on the mode output)
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_FILL = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    // Command encoding on the cmd input
    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_FILL = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    function automatic logic [1:0] cmd_to_mode(input logic [1:0] c);
        logic [1:0] m;
        case (c)
            CMD_STOP: m = MODE_IDLE;
            CMD_RUN:  m = MODE_RUN;
            CMD_FILL: m = MODE_FILL;
            default:  m = MODE_STEP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/femto_istore.sv
// -----------------------------------------------------------------------------
// femto_istore
//   ENTRIES x IW instruction register array.
//   Ports:
//     clk, rst_n  clock / async active-low clear of every entry
//     we, waddr, wdata   synchronous write port
//     raddr, rdata       combinational read port (0 when raddr is out of range)
// -----------------------------------------------------------------------------
module femto_istore
    import femto_pkg::*;
#(
    parameter int ENTRIES = 6,
    parameter int IW      = INSTR_W,
    parameter int PW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [ENTRIES];

    // NOTE: this array is small flops, not a RAM macro, so it can and must be
    // cleared by reset; a RAM-style store would be left out of the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The sequencer keeps raddr below count, but guard the index anyway so an
    // unused pointer value can never select a non-existent entry.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < ENTRIES) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/femto_sequencer.sv
// -----------------------------------------------------------------------------
// femto_sequencer
//   Instruction sequencer for the 4-bit femto datapath. Holds a small
//   instruction store that is filled sequentially and then issued either
//   continuously (RUN, looping over the filled length) or one at a time (STEP).
//   Ports:
//     clk, rst_n              clock / async active-low reset
//     cmd_valid, cmd          one-cycle mode command (STOP/RUN/FILL/STEP)
//     wr_valid, wr_instr      instruction write, honoured in FILL only
//     instr_out, instr_valid  registered issued instruction + qualifier
//     mode, pc, count         registered state
//     full                    count == ENTRIES
//     overflow                sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module femto_sequencer
    import femto_pkg::*;
#(
    parameter int ENTRIES = 6,
    parameter int IW      = INSTR_W,
    parameter int PW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd,
    input  logic          wr_valid,
    input  logic [IW-1:0] wr_instr,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [1:0]    mode,
    output logic [PW-1:0] pc,
    output logic [PW-1:0] count,
    output logic          full,
    output logic          overflow
);

    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;

    logic          issue;
    logic          wr_accept;
    logic          we;
    logic [IW-1:0] rdata;

    assign full = (count_q == PW'(ENTRIES));

    // RUN and STEP both issue mem[pc] on the edge that leaves the state's cycle,
    // including the cycle a command arrives in.
    assign issue     = ((mode_q == MODE_RUN) || (mode_q == MODE_STEP)) && (count_q != '0);
    // A command in the same cycle wins over a write.
    assign wr_accept = (mode_q == MODE_FILL) && wr_valid && !cmd_valid;
    assign we        = wr_accept && !full;

    femto_istore #(
        .ENTRIES (ENTRIES),
        .IW      (IW),
        .PW      (PW)
    ) u_istore (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (count_q),
        .wdata (wr_instr),
        .raddr (pc_q),
        .rdata (rdata)
    );

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        mode_d  = mode_q;
        pc_d    = pc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = issue;
        instr_d = issue ? rdata : {{(IW-OP_W){1'b0}}, OP_NOP};

        if (issue) begin
            pc_d = (pc_q == count_q - PW'(1)) ? '0 : pc_q + PW'(1);
        end

        if (wr_accept) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + PW'(1);
            end
        end

        // Entry actions override the issue-driven pc update above.
        if (cmd_valid) begin
            mode_d = cmd_to_mode(cmd);
            case (cmd)
                CMD_FILL: begin
                    count_d = '0;
                    pc_d    = '0;
                    ovf_d   = 1'b0;
                end
                CMD_RUN: begin
                    if (mode_q == MODE_FILL) begin
                        pc_d = '0;
                    end
                end
                default: ;
            endcase
        end else if (mode_q == MODE_STEP) begin
            mode_d = MODE_IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign mode        = mode_q;
    assign pc          = pc_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;

endmodule
